// File: rtl/stage_fetch.sv
// Fetch stage: Avalon-MM read master with one outstanding read, a one-word
// holding buffer for decode stalls, and redirect handling for EX branches.
module stage_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        de_stall,
  input  logic        de_clear,
  input  logic        pc_redirect,
  input  logic [31:0] pc_target,
  output logic [31:0] avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic [31:0] de_instr,
  output logic [31:0] de_pc,
  output logic [31:0] de_pc_plus4,
  output logic        de_valid
);
  typedef enum logic [1:0] {RST, REQ, WAIT, HOLD} state_t;

  state_t      state, state_nx;
  logic [31:0] req_addr, req_addr_nx;
  logic [31:0] tgt, tgt_nx;
  logic [31:0] hold_word, hold_word_nx;
  logic [31:0] handoff_word, redirect_addr;
  logic        discard, discard_nx;
  logic        handoff, go;

  assign redirect_addr = {pc_target[31:2], 2'b00};
  assign go            = !de_stall && !de_clear;
  assign avm_read      = (state == REQ);
  assign avm_address   = req_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RST;
      req_addr  <= RESET_PC;
      tgt       <= 32'd0;
      hold_word <= 32'd0;
      discard   <= 1'b0;
    end else begin
      state     <= state_nx;
      req_addr  <= req_addr_nx;
      tgt       <= tgt_nx;
      hold_word <= hold_word_nx;
      discard   <= discard_nx;
    end
  end

  // discard doubles as "a saved target is pending": both are always set together.
  always_comb begin
    state_nx     = state;
    req_addr_nx  = req_addr;
    tgt_nx       = tgt;
    hold_word_nx = hold_word;
    discard_nx   = discard;
    handoff      = 1'b0;
    handoff_word = hold_word;
    unique case (state)
      RST: begin
        state_nx = REQ;
        if (pc_redirect) req_addr_nx = redirect_addr;
      end
      REQ: begin
        if (pc_redirect) begin
          discard_nx = 1'b1;
          tgt_nx     = redirect_addr;
        end
        if (!avm_waitrequest) state_nx = WAIT;
      end
      WAIT: begin
        if (avm_readdatavalid) begin
          state_nx = REQ;
          if (pc_redirect) begin
            req_addr_nx = redirect_addr;
            discard_nx  = 1'b0;
          end else if (discard) begin
            req_addr_nx = tgt;
            discard_nx  = 1'b0;
          end else if (go) begin
            handoff      = 1'b1;
            handoff_word = avm_readdata;
            req_addr_nx  = req_addr + 32'd4;
          end else begin
            state_nx     = HOLD;
            hold_word_nx = avm_readdata;
          end
        end else if (pc_redirect) begin
          discard_nx = 1'b1;
          tgt_nx     = redirect_addr;
        end
      end
      HOLD: begin
        if (pc_redirect) begin
          state_nx    = REQ;
          req_addr_nx = redirect_addr;
        end else if (go) begin
          state_nx    = REQ;
          handoff     = 1'b1;
          req_addr_nx = req_addr + 32'd4;
        end
      end
    endcase
  end

  // Decode register: clear beats stall; an unstalled cycle without a handoff is a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de_instr    <= NOP_INSTR;
      de_pc       <= 32'd0;
      de_pc_plus4 <= 32'd0;
      de_valid    <= 1'b0;
    end else if (de_clear || (!de_stall && !handoff)) begin
      de_instr    <= NOP_INSTR;
      de_pc       <= 32'd0;
      de_pc_plus4 <= 32'd0;
      de_valid    <= 1'b0;
    end else if (!de_stall) begin
      de_instr    <= handoff_word;
      de_pc       <= req_addr;
      de_pc_plus4 <= req_addr + 32'd4;
      de_valid    <= 1'b1;
    end
  end
endmodule

// File: tb/tb_stage_fetch.sv
// Directed bench for stage_fetch: memory slave with programmable wait/latency,
// an instruction-stream model checked every cycle, and literal scenario checks.
module tb_stage_fetch;
  localparam logic [31:0] MAGIC = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        de_stall, de_clear, pc_redirect;
  logic [31:0] pc_target;
  logic [31:0] avm_address;
  logic        avm_read, avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;
  logic [31:0] de_instr, de_pc, de_pc_plus4;
  logic        de_valid;

  stage_fetch dut (
    .clk(clk), .rst_n(rst_n),
    .de_stall(de_stall), .de_clear(de_clear),
    .pc_redirect(pc_redirect), .pc_target(pc_target),
    .avm_address(avm_address), .avm_read(avm_read),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid),
    .de_instr(de_instr), .de_pc(de_pc), .de_pc_plus4(de_pc_plus4),
    .de_valid(de_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // directed controls, applied to the DUT by cyc()
  logic        stall, clr, redir, wr;
  logic [31:0] tgt;
  int          lat;
  // memory slave state
  logic        pend;
  logic [31:0] paddr;
  int          cnt;
  logic [31:0] acc_q[$];
  logic [31:0] dlv_q[$];
  int          dlv_c[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Called at a falling edge: apply controls and slave response, advance one cycle.
  task automatic cyc();
    avm_readdatavalid = 1'b0;
    avm_readdata      = 32'hDEAD_BEEF;
    if (pend) begin
      if (cnt == 0) begin
        avm_readdatavalid = 1'b1;
        avm_readdata      = paddr ^ MAGIC;
        pend              = 1'b0;
      end else cnt--;
    end
    avm_waitrequest = wr;
    if (rst_n && avm_read && !wr) begin
      pend  = 1'b1;
      paddr = avm_address;
      cnt   = lat - 1;
      acc_q.push_back(avm_address);
    end
    de_stall    = stall;
    de_clear    = clr;
    pc_redirect = redir;
    pc_target   = tgt;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_req(input logic [31:0] a);
    int n = 0;
    while (!(avm_read && avm_address == a) && n < 20) begin
      cyc();
      n++;
    end
    chk("reach_req", 32'(avm_read && avm_address == a), 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; stall = 1'b0; clr = 1'b0; redir = 1'b0; wr = 1'b0; lat = 1;
    cyc();
    cyc();
    pend = 1'b0;
    acc_q.delete(); dlv_q.delete(); dlv_c.delete();
    rst_n = 1'b1;
  endtask

  // Stream model: delivered instructions must follow program order from the
  // last reset/redirect, carry memory contents, and respect clear/stall/bubble rules.
  initial begin : model
    logic        s_rst, s_stall, s_clr, s_redir, s_wait;
    logic [31:0] s_tgt, exp_pc;
    logic        pr_ok, pr_read;
    logic [31:0] pr_addr, pr_instr, pr_pc, pr_p4;
    logic        pr_valid;
    int          ncyc;
    exp_pc = 32'd0; pr_ok = 1'b0; pr_read = 1'b0; pr_addr = 32'd0;
    pr_instr = 32'd0; pr_pc = 32'd0; pr_p4 = 32'd0; pr_valid = 1'b0; ncyc = 0;
    forever begin
      @(posedge clk);
      s_rst = rst_n; s_stall = de_stall; s_clr = de_clear;
      s_redir = pc_redirect; s_tgt = pc_target; s_wait = avm_waitrequest;
      #1;
      ncyc++;
      if (!s_rst || !rst_n) begin
        chk("rst_read", 32'(avm_read), 32'd0);
        chk("rst_addr", avm_address, 32'd0);
        chk("rst_valid", 32'(de_valid), 32'd0);
        chk("rst_pc", de_pc, 32'd0);
        exp_pc = 32'd0;
        pr_ok  = 1'b0;
      end else begin
        if (pr_ok && pr_read && s_wait) begin
          chk("hold_read", 32'(avm_read), 32'd1);
          chk("hold_addr", avm_address, pr_addr);
        end
        chk("addr_align", {30'd0, avm_address[1:0]}, 32'd0);
        if (s_clr) begin
          chk("clr_valid", 32'(de_valid), 32'd0);
          chk("clr_instr", de_instr, 32'd0);
          chk("clr_pc", de_pc, 32'd0);
        end else if (s_stall) begin
          chk("stall_instr", de_instr, pr_instr);
          chk("stall_pc", de_pc, pr_pc);
          chk("stall_p4", de_pc_plus4, pr_p4);
          chk("stall_valid", 32'(de_valid), 32'(pr_valid));
        end else begin
          if (s_redir) chk("redir_override", 32'(de_valid), 32'd0);
          if (de_valid) begin
            chk("m_pc", de_pc, exp_pc);
            chk("m_instr", de_instr, exp_pc ^ MAGIC);
            chk("m_p4", de_pc_plus4, exp_pc + 32'd4);
            dlv_q.push_back(de_pc);
            dlv_c.push_back(ncyc);
            exp_pc = exp_pc + 32'd4;
          end else begin
            chk("bub_instr", de_instr, 32'd0);
            chk("bub_pc", de_pc, 32'd0);
            chk("bub_p4", de_pc_plus4, 32'd0);
          end
        end
        if (s_redir) exp_pc = {s_tgt[31:2], 2'b00};
        pr_ok = 1'b1;
      end
      pr_read = avm_read; pr_addr = avm_address; pr_instr = de_instr;
      pr_pc = de_pc; pr_p4 = de_pc_plus4; pr_valid = de_valid;
    end
  end

  initial begin : stim
    int n;
    rst_n = 1'b0; stall = 1'b0; clr = 1'b0; redir = 1'b0; tgt = 32'd0; wr = 1'b0; lat = 1;
    pend = 1'b0; paddr = 32'd0; cnt = 0;
    de_stall = 1'b0; de_clear = 1'b0; pc_redirect = 1'b0; pc_target = 32'd0;
    avm_waitrequest = 1'b0; avm_readdata = 32'h1234_5678; avm_readdatavalid = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("reset_read", 32'(avm_read), 32'd0);
    chk("reset_addr", avm_address, 32'd0);
    chk("reset_instr", de_instr, 32'd0);
    chk("reset_p4", de_pc_plus4, 32'd0);
    chk("reset_valid", 32'(de_valid), 32'd0);

    // 1: zero-wait streaming
    rst_n = 1'b1;
    n = 0;
    while (dlv_q.size() < 3 && n < 20) begin cyc(); n++; end
    chk("t1_count", 32'(dlv_q.size()), 32'd3);
    chk("t1_pc0", dlv_q[0], 32'h0);
    chk("t1_pc1", dlv_q[1], 32'h4);
    chk("t1_pc2", dlv_q[2], 32'h8);
    chk("t1_rd1", acc_q[1], 32'h4);
    chk("t1_rd2", acc_q[2], 32'h8);
    chk("t1_gap0", 32'(dlv_c[1] - dlv_c[0]), 32'd2);
    chk("t1_gap1", 32'(dlv_c[2] - dlv_c[1]), 32'd2);

    // 2: waitrequest held 3 cycles at 0x4
    do_reset();
    wait_req(32'h4);
    wr = 1'b1;
    repeat (3) begin
      cyc();
      chk("t2_read", 32'(avm_read), 32'd1);
      chk("t2_addr", avm_address, 32'h4);
      chk("t2_valid", 32'(de_valid), 32'd0);
    end
    wr = 1'b0;

    // 3: stall 4 cycles while the 0x8 word returns
    wait_req(32'h8);
    stall = 1'b1;
    repeat (4) begin
      cyc();
      chk("t3_hold_pc", de_pc, 32'h4);
      chk("t3_hold_valid", 32'(de_valid), 32'd1);
      chk("t3_no_read", 32'(avm_read), 32'd0);
    end
    stall = 1'b0;
    cyc();
    chk("t3_pc", de_pc, 32'h8);
    chk("t3_instr", de_instr, 32'hA5A5_0008);
    chk("t3_p4", de_pc_plus4, 32'hC);

    // 4: redirect to 0x103 while waiting on 0xC
    lat = 2;
    cyc();
    redir = 1'b1; tgt = 32'h103;
    cyc();
    redir = 1'b0;
    chk("t4_valid_a", 32'(de_valid), 32'd0);
    cyc();
    chk("t4_valid_b", 32'(de_valid), 32'd0);
    chk("t4_addr", avm_address, 32'h100);
    chk("t4_read", 32'(avm_read), 32'd1);
    lat = 1;
    cyc(); cyc();
    chk("t4_pc", de_pc, 32'h100);
    chk("t4_dv", 32'(de_valid), 32'd1);

    // 5: redirect to 0x200 in REQ under waitrequest
    wr = 1'b1; redir = 1'b1; tgt = 32'h200;
    cyc();
    redir = 1'b0;
    chk("t5_old_a", avm_address, 32'h104);
    cyc();
    chk("t5_old_b", avm_address, 32'h104);
    wr = 1'b0;
    cyc(); cyc();
    chk("t5_addr", avm_address, 32'h200);
    chk("t5_dropped", 32'(de_valid), 32'd0);
    cyc(); cyc();
    chk("t5_pc", de_pc, 32'h200);

    // 7: redirect on the accept cycle to an unaligned top address; pc+4 wraps
    redir = 1'b1; tgt = 32'hFFFF_FFFE;
    cyc();
    redir = 1'b0;
    cyc();
    chk("t7_addr", avm_address, 32'hFFFF_FFFC);
    chk("t7_dropped", 32'(de_valid), 32'd0);
    cyc(); cyc();
    chk("t7_pc", de_pc, 32'hFFFF_FFFC);
    chk("t7_p4", de_pc_plus4, 32'h0);
    chk("t7_next", avm_address, 32'h0);

    // 8: clear on the return cycle parks the word; delivered after clear drops
    cyc();
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    chk("t8_bubble", 32'(de_valid), 32'd0);
    chk("t8_no_read", 32'(avm_read), 32'd0);
    cyc();
    chk("t8_pc", de_pc, 32'h0);
    chk("t8_instr", de_instr, 32'hA5A5_0000);

    // 6: reset mid-WAIT, stale response arrives after release
    lat = 3;
    cyc();
    chk("t6_in_wait", 32'(avm_read), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_read", 32'(avm_read), 32'd0);
    chk("t6_rst_addr", avm_address, 32'd0);
    chk("t6_rst_pc", de_pc, 32'd0);
    cyc();
    rst_n = 1'b1;
    cyc();
    wr = 1'b1;
    cyc();
    chk("t6_read", 32'(avm_read), 32'd1);
    chk("t6_addr", avm_address, 32'd0);
    chk("t6_stale", 32'(de_valid), 32'd0);
    wr = 1'b0; lat = 1;
    cyc(); cyc();
    chk("t6_pc", de_pc, 32'd0);
    chk("t6_dv", 32'(de_valid), 32'd1);
    chk("t6_instr", de_instr, 32'hA5A5_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
